// File: rtl/receptor_medida_uc.sv
// Receive-side parser for measurement ("ddd#") and acerto ("A#") frames.
// Optional inter-character timeout: define RECEPTOR_TIMEOUT_EN.
module receptor_medida_uc #(
  parameter int NUM_DIGITS     = 3,
  parameter int TIMEOUT_CICLOS = 50000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pronto_rx,
  input  logic [6:0]              dado_rx,
  output logic [4*NUM_DIGITS-1:0] medida,
  output logic                    medida_valida,
  output logic                    acertou,
  output logic                    erro,
  output logic [3:0]              db_estado
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    DIGITOS      = 4'd1,
    ACERTO       = 4'd2,
    REGISTRA     = 4'd3,
    PULSO_ACERTO = 4'd4,
    ERRO_ST      = 4'd5,
    DESCARTA     = 4'd6
  } estado_t;

  estado_t         state_q, state_d;
  logic [W-1:0]    buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    medida_q, medida_d;
  logic            eh_digito, eh_fim, eh_a;
  logic [3:0]      bcd;
  logic            estouro;

  // Character classification of the incoming byte
  always_comb begin
    bcd       = dado_rx[3:0];
    eh_digito = (dado_rx[6:4] == 3'b011) && (dado_rx[3:0] <= 4'd9);
    eh_fim    = (dado_rx == 7'h23);
    eh_a      = (dado_rx == 7'h41);
  end

`ifdef RECEPTOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          espera;

  // Idle-cycle counter; restarts on every character and on state change
  always_comb begin
    espera  = (state_q == DIGITOS) || (state_q == ACERTO) ||
              (state_q == DESCARTA);
    estouro = espera && !pronto_rx &&
              (tmo_q == TW'(TIMEOUT_CICLOS - 1));
    if (!espera || pronto_rx || (state_d != state_q))
      tmo_d = '0;
    else
      tmo_d = tmo_q + TW'(1);
  end

  // Timeout counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  // Without the timeout the parser waits indefinitely
  assign estouro = 1'b0;
`endif

  // Next-state logic and Moore outputs
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    medida_d      = medida_q;
    medida_valida = 1'b0;
    acertou       = 1'b0;
    erro          = 1'b0;
    db_estado     = state_q;
    case (state_q)
      INICIAL: begin
        if (pronto_rx) begin
          if (eh_digito) begin
            buf_d   = W'(bcd);
            cnt_d   = CW'(1);
            state_d = DIGITOS;
          end else if (eh_a) begin
            state_d = ACERTO;
          end else begin
            state_d = ERRO_ST;
          end
        end
      end
      DIGITOS: begin
        if (pronto_rx) begin
          if (eh_digito && (cnt_q < CW'(NUM_DIGITS))) begin
            buf_d = W'({buf_q, bcd});
            cnt_d = cnt_q + CW'(1);
          end else if (eh_fim && (cnt_q == CW'(NUM_DIGITS))) begin
            state_d = REGISTRA;
          end else begin
            state_d = ERRO_ST;
          end
        end else if (estouro) begin
          state_d = ERRO_ST;
        end
      end
      ACERTO: begin
        if (pronto_rx)
          state_d = eh_fim ? PULSO_ACERTO : ERRO_ST;
        else if (estouro)
          state_d = ERRO_ST;
      end
      REGISTRA: begin
        medida_d      = buf_q;
        medida_valida = 1'b1;
        state_d       = INICIAL;
      end
      PULSO_ACERTO: begin
        acertou = 1'b1;
        state_d = INICIAL;
      end
      ERRO_ST: begin
        erro    = 1'b1;
        state_d = DESCARTA;
      end
      DESCARTA: begin
        if (pronto_rx) begin
          if (eh_fim) state_d = INICIAL;
        end else if (estouro) begin
          state_d = INICIAL;
        end
      end
      default: begin
        state_d   = INICIAL;
        db_estado = 4'b1111;
      end
    endcase
  end

  // State, digit buffer and measurement registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= INICIAL;
      buf_q    <= '0;
      cnt_q    <= '0;
      medida_q <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      medida_q <= medida_d;
    end
  end

  assign medida = medida_q;

endmodule
